// File: rtl/ram_apb_slave_param_pkg.sv
// Shared constants, FSM encoding and helpers for the parametrised APB RAM slave.
package ram_apb_slave_param_pkg;

  localparam int unsigned APB_ADDR_WIDTH   = 32;
  localparam int unsigned APB_DATA_WIDTH   = 32;
  localparam int unsigned APB_STROBE_WIDTH = APB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_apb_slave_param_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module ram_apb_slave_param_ram
  import ram_apb_slave_param_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
  parameter int unsigned IDX_W      = clog2(DEPTH),
  parameter int unsigned STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     be,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read-before-write: rdata shows the old word on a same-cycle write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_apb_slave_param.sv
// APB4 RAM slave: configurable geometry, programmable wait states, byte strobes,
// range/alignment error reporting and a privileged-only locked low region.
module ram_apb_slave_param
  import ram_apb_slave_param_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned LOCK_WORDS  = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [2:0]              pprot,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic                    pslverr,
  output logic [DATA_WIDTH-1:0]   prdata
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = clog2(DEPTH);
  localparam int unsigned OFF    = clog2(STRB_W);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

  apb_state_e            state_q;
  logic [3:0]            cnt_q;
  logic                  pready_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic                  err_q;
  logic [STRB_W-1:0]     strb_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]      idx;
  logic                  err;
  logic                  start;
  logic                  ram_we;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_prot;

  assign unused_prot = ^pprot[2:1];

  // Full-width compares so upper address bits can never alias into the array.
  assign word_addr = paddr >> OFF;
  assign idx       = word_addr[IDX_W-1:0];
  assign err       = (|(paddr & ALIGN_MASK))
                   | (word_addr >= ADDR_WIDTH'(DEPTH))
                   | (pwrite & (word_addr < ADDR_WIDTH'(LOCK_WORDS)) & ~pprot[0]);
  assign start     = psel & ~penable;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      pready_q <= 1'b0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      strb_q   <= '0;
      wdata_q  <= '0;
    end else if (start) begin
      state_q  <= StSetup;
      cnt_q    <= CNT_INIT;
      pready_q <= (WAIT_STATES == 0);
      idx_q    <= idx;
      write_q  <= pwrite;
      err_q    <= err;
      strb_q   <= pstrb;
      wdata_q  <= pwdata;
    end else begin
      unique case (state_q)
        StSetup, StAccess: begin
          if (!psel || pready_q) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            pready_q <= 1'b0;
          end else begin
            state_q  <= StAccess;
            cnt_q    <= cnt_q - 4'd1;
            pready_q <= (cnt_q == 4'd1);
          end
        end
        default: begin
          state_q  <= StIdle;
          pready_q <= 1'b0;
        end
      endcase
    end
  end

  // Gating with psel drops the completion if the master abandons the access.
  assign pready   = pready_q & psel;
  assign pslverr  = pready & err_q;
  assign prdata   = (pready & ~write_q & ~err_q) ? ram_rdata : '0;
  assign ram_we   = pready & write_q & ~err_q;
  assign ram_addr = start ? idx : idx_q;

  ram_apb_slave_param_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (pclk),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .be    (strb_q & {STRB_W{ram_we}}),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_ram_apb_slave_param.sv
// Directed bench for ram_apb_slave_param: scoreboard of expected responses plus a word model.
module tb_ram_apb_slave_param;

  localparam int unsigned WS    = 1;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LOCK  = 16;
  localparam int          BOUND = 20;

  logic        pclk = 1'b0;
  logic        preset;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[int];
  int          checks = 0;
  int          passes = 0;

  ram_apb_slave_param #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS),
    .LOCK_WORDS  (LOCK)
  ) dut (
    .pclk    (pclk),
    .preset  (preset),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pprot   (pprot),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pstrb   (pstrb),
    .pready  (pready),
    .pslverr (pslverr),
    .prdata  (prdata)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] addr, input logic wr,
                                     input logic [2:0] prot);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH) ||
           (wr && ((addr >> 2) < LOCK) && !prot[0]);
  endfunction

  // Starts immediately (back-to-back when called right after another transfer).
  task automatic xfer(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic wr, input logic [3:0] strb, input logic [2:0] prot);
    exp_t e;
    int   cyc;
    e.tag = tag;
    e.err = model_err(addr, wr, prot);
    e.data = 32'h0;
    if (wr) begin
      if (!e.err) begin
        for (int i = 0; i < 4; i++) begin
          if (strb[i]) model[int'(addr >> 2)][8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end else if (!e.err) begin
      e.data = model[int'(addr >> 2)];
    end
    sb.push_back(e);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwdata = wdata;
    pwrite = wr; pstrb = strb; pprot = prot;
    @(posedge pclk); #1 penable = 1'b1;
    cyc = 1;
    @(negedge pclk);
    while (!pready && cyc < BOUND) begin
      check({tag, "_wait_out"}, {31'h0, pslverr, prdata}, 64'h0);
      @(negedge pclk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(WS + 1));
    e = sb.pop_front();
    check({e.tag, "_prdata"}, 64'(prdata), 64'(e.data));
    check({e.tag, "_pslverr"}, 64'(pslverr), 64'(e.err));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(posedge pclk);
    #1 check("reset_outputs", {31'h0, pready, pslverr, prdata}, 64'h0);
    preset = 1'b0;
    idle(2);

    xfer("init_w0", 32'h0, 32'h13579BDF, 1'b1, 4'hF, 3'b001);
    xfer("wr_100", 32'h100, 32'hDEADBEEF, 1'b1, 4'hF, 3'b000);
    xfer("rd_100", 32'h100, 32'h0, 1'b0, 4'hF, 3'b000);
    xfer("wr_100_strb", 32'h100, 32'h11223344, 1'b1, 4'b0101, 3'b000);
    xfer("rd_100_strb", 32'h100, 32'h0, 1'b0, 4'h0, 3'b000);
    check("model_strb", 64'(model[32'h40]), 64'hDE22BE44);
    xfer("wr_100_nostrb", 32'h100, 32'hFFFFFFFF, 1'b1, 4'h0, 3'b000);
    xfer("rd_100_nostrb", 32'h100, 32'h0, 1'b0, 4'hF, 3'b000);
    idle(1);

    xfer("rd_range", 32'h1000, 32'h0, 1'b0, 4'hF, 3'b001);
    xfer("wr_range", 32'h1000, 32'hFFFF0000, 1'b1, 4'hF, 3'b001);
    xfer("rd_w0_after_range", 32'h0, 32'h0, 1'b0, 4'hF, 3'b000);
    xfer("wr_misalign", 32'h102, 32'h55555555, 1'b1, 4'hF, 3'b001);
    xfer("rd_100_after_misalign", 32'h100, 32'h0, 1'b0, 4'hF, 3'b000);
    xfer("wr_lock_user", 32'h0, 32'hA5A5A5A5, 1'b1, 4'hF, 3'b000);
    xfer("rd_lock_user", 32'h0, 32'h0, 1'b0, 4'hF, 3'b000);
    xfer("wr_lock_priv", 32'h0, 32'hA5A5A5A5, 1'b1, 4'hF, 3'b001);
    xfer("rd_lock_priv", 32'h0, 32'h0, 1'b0, 4'hF, 3'b000);
    check("model_lock", 64'(model[0]), 64'hA5A5A5A5);
    idle(3);

    // Asynchronous reset while idle: outputs must be low before the next edge.
    @(negedge pclk); #1 preset = 1'b1;
    #1 check("reset_idle", {31'h0, pready, pslverr, prdata}, 64'h0);
    @(posedge pclk); #1 preset = 1'b0;
    idle(1);

    // Asynchronous reset in the middle of a read's ready cycle.
    psel = 1'b1; penable = 1'b0; paddr = 32'h100; pwrite = 1'b0; pstrb = 4'hF; pprot = 3'b000;
    @(posedge pclk); #1 penable = 1'b1;
    repeat (WS + 1) @(negedge pclk);
    check("rd_before_reset_ready", 64'(pready), 64'h1);
    #1 preset = 1'b1;
    #1 check("reset_in_ready", {31'h0, pready, pslverr, prdata}, 64'h0);
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1 preset = 1'b0;
    idle(1);

    // Reset inside the wait state of a write must commit nothing.
    xfer("wr_200_init", 32'h200, 32'hCAFEF00D, 1'b1, 4'hF, 3'b000);
    idle(1);
    psel = 1'b1; penable = 1'b0; paddr = 32'h200; pwdata = 32'h12345678;
    pwrite = 1'b1; pstrb = 4'hF; pprot = 3'b000;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    check("wr_200_wait", 64'(pready), 64'h0);
    #1 preset = 1'b1;
    #1 check("reset_in_wait", {31'h0, pready, pslverr, prdata}, 64'h0);
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1 preset = 1'b0;
    idle(1);
    xfer("rd_200_after_abort", 32'h200, 32'h0, 1'b0, 4'hF, 3'b000);
    xfer("wr_200_b2b", 32'h200, 32'h0F0F0F0F, 1'b1, 4'hF, 3'b000);
    xfer("rd_200_b2b", 32'h200, 32'h0, 1'b0, 4'hF, 3'b000);
    check("model_200", 64'(model[32'h80]), 64'h0F0F0F0F);
    check("sb_empty", 64'(sb.size()), 64'h0);
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
